// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the core's word-addressed data memory.
//   DATA_MEM_ADDR_WIDTH : default word-address width (depth = 2**width)
//   DATA_MEM_DATA_WIDTH : default word width in bits
//   word_t              : one memory word
//   ZERO_WORD           : value of a cleared / unread word
// -----------------------------------------------------------------------------
package data_mem_pkg;

  localparam int DATA_MEM_ADDR_WIDTH = 10;
  localparam int DATA_MEM_DATA_WIDTH = 32;

  typedef logic [DATA_MEM_DATA_WIDTH-1:0] word_t;

  localparam word_t ZERO_WORD = '0;

endpackage : data_mem_pkg

// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
// Word-addressed data memory serving load/store instructions of the
// single-cycle RISC-V core. Writes land on the rising edge of clk; reads are
// combinational and return zero whenever MemRead is low or reset is active.
// A synchronous active-low reset clears every word to zero and takes priority
// over a write on the same edge.
//
// Ports:
//   clk        in   system clock, all state changes on the rising edge
//   rst_n      in   synchronous active-low reset, clears the whole array
//   MemRead    in   read enable, qualifies read_data
//   MemWrite   in   write enable, sampled on the rising edge
//   addr       in   word address [ADDR_WIDTH-1:0], full range valid
//   write_data in   store data [DATA_WIDTH-1:0]
//   read_data  out  load data [DATA_WIDTH-1:0], combinational
//
// Optional build macro:
//   DATA_MEM_ASSERT_EN - compiles in simulation-only protocol checks
//   (X/Z on enables or address, simultaneous read and write). Functional
//   behaviour is identical with or without it.
// -----------------------------------------------------------------------------
module data_mem
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DATA_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DATA_MEM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = DATA_WIDTH'(ZERO_WORD);

  // Storage. Every location is given a defined value by reset, so no X can
  // leave the array once the core has been reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Write / clear process
  // ---------------------------------------------------------------------------
  // NOTE: the whole array is cleared on reset, which forces flop-based storage
  // rather than a RAM macro; zero-after-reset is part of this block's contract,
  // so the cost is accepted. Reset is checked first so a store issued in a
  // reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= ZERO_DATA;
      end
    end else if (MemWrite) begin
      mem_q[addr] <= write_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  // Reads the stored array only, never write_data: a same-address read during
  // a write shows the old word until the edge and the new word after it.
  // NOTE: read_data gets a default before the conditional so no latch is
  // inferred when the enable is low.
  always_comb begin
    read_data = ZERO_DATA;
    if (MemRead && rst_n) begin
      read_data = mem_q[addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Simulation-only protocol checks
  // ---------------------------------------------------------------------------
`ifdef DATA_MEM_ASSERT_EN
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if ($isunknown(MemWrite)) begin
        $error("data_mem: MemWrite is X/Z");
      end
      if ($isunknown(MemRead)) begin
        $error("data_mem: MemRead is X/Z");
      end
      if (((MemWrite === 1'b1) || (MemRead === 1'b1)) && $isunknown(addr)) begin
        $error("data_mem: addr is X/Z while an enable is active");
      end
      if ((MemWrite === 1'b1) && (MemRead === 1'b1)) begin
        $warning("data_mem: MemRead and MemWrite both active in the same cycle");
      end
    end
  end
`else
  // No checking logic in the default build.
`endif

endmodule : data_mem

// File: tb/tb_data_mem.sv
// -----------------------------------------------------------------------------
// tb_data_mem
// Self-checking bench for data_mem. A reference model (associative array of
// written words, emptied on reset) predicts read_data; a compare process
// checks the DUT against it on every falling edge. A directed sequence with
// literal expectations pins the model, followed by randomized traffic.
// Inputs change 1 time unit after each rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_data_mem;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          MemRead;
  logic          MemWrite;
  logic [AW-1:0] addr;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;

  int total;
  int bad;
  bit compare_on;

  // Reference model: only written words are present; anything absent reads 0.
  logic [DW-1:0] model [int];

  data_mem #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .addr      (addr),
    .write_data(write_data),
    .read_data (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: read_data=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input int a);
    if (model.exists(a)) return model[a];
    return '0;
  endfunction

  // Model update on the same edge the DUT uses.
  always @(posedge clk) begin
    if (rst_n === 1'b0) begin
      model.delete();
    end else if (MemWrite === 1'b1) begin
      model[int'(addr)] = write_data;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (compare_on) begin
      if ((MemRead === 1'b1) && (rst_n === 1'b1))
        check("model", read_data, model_read(int'(addr)));
      else
        check("model_idle", read_data, '0);
    end
  end

  task automatic drive(input logic r, input logic rd, input logic wr,
                       input int a, input logic [DW-1:0] d);
    rst_n      = r;
    MemRead    = rd;
    MemWrite   = wr;
    addr       = AW'(a);
    write_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Literal expectation in the current cycle, then advance one edge.
  task automatic expect_now(input string name, input logic [DW-1:0] exp);
    @(negedge clk);
    check(name, read_data, exp);
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    compare_on = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 0, '0);
    tick();
    compare_on = 1'b1;
    tick();

    // Reset released: nothing written yet.
    drive(1'b1, 1'b1, 1'b0, 5, '0);
    expect_now("after_reset_a5", 32'd0);

    // Write 123 to addr 5, read back in the same cycle it is requested.
    drive(1'b1, 1'b0, 1'b1, 5, 32'd123);
    tick();
    drive(1'b1, 1'b1, 1'b0, 5, '0);
    expect_now("read_a5_123", 32'd123);

    drive(1'b1, 1'b1, 1'b0, 10, '0);
    expect_now("unwritten_a10", 32'd0);
    drive(1'b1, 1'b0, 1'b0, 5, '0);
    expect_now("memread_low", 32'd0);

    // Overwrite addr 5 with 77 while not reading.
    drive(1'b1, 1'b0, 1'b1, 5, 32'd77);
    tick();
    drive(1'b1, 1'b1, 1'b0, 5, '0);
    expect_now("overwrite_a5", 32'd77);
    drive(1'b1, 1'b1, 1'b0, 4, '0);
    expect_now("neighbour_a4", 32'd0);
    drive(1'b1, 1'b1, 1'b0, 6, '0);
    expect_now("neighbour_a6", 32'd0);

    // Address extremes.
    drive(1'b1, 1'b0, 1'b1, 1023, 32'hFFFF_FFFF);
    tick();
    drive(1'b1, 1'b0, 1'b1, 0, 32'hA5A5_A5A5);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1023, '0);
    expect_now("top_a1023", 32'hFFFF_FFFF);
    drive(1'b1, 1'b1, 1'b0, 0, '0);
    expect_now("bottom_a0", 32'hA5A5_A5A5);

    // Same-address read and write: old word before the edge, new after.
    drive(1'b1, 1'b0, 1'b1, 8, 32'd11);
    tick();
    drive(1'b1, 1'b1, 1'b1, 8, 32'd22);
    expect_now("rw_same_old", 32'd11);
    drive(1'b1, 1'b1, 1'b0, 8, '0);
    expect_now("rw_same_new", 32'd22);

    // Store during reset is dropped; reset clears earlier contents.
    drive(1'b0, 1'b1, 1'b1, 7, 32'd55);
    expect_now("read_in_reset", 32'd0);
    drive(1'b1, 1'b1, 1'b0, 7, '0);
    expect_now("write_in_reset_a7", 32'd0);
    drive(1'b1, 1'b1, 1'b0, 5, '0);
    expect_now("reset_cleared_a5", 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1023, '0);
    expect_now("reset_cleared_a1023", 32'd0);

    // Randomized traffic; a narrow address window forces frequent reuse.
    for (int i = 0; i < 3000; i++) begin
      int a;
      logic r;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 2 ** AW - 1);
      else a = $urandom_range(0, 15);
      r = ($urandom_range(0, 79) != 0);
      drive(r, 1'($urandom), 1'($urandom), a, $urandom);
      tick();
    end

    drive(1'b1, 1'b0, 1'b0, 0, '0);
    tick();
    compare_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_data_mem
